// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: shared FSM state encodings and default operand width for serial_compare_ctrl
package serial_cmp_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMPARE = 2'b01,
        DONE    = 2'b10
    } state_t;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/comparator_1bit.sv
// comparator_1bit: one MSB-first magnitude-compare step
// Ports: a_bit/b_bit operand bits, lt_in/eq_in running result, lt_out/eq_out updated result
module comparator_1bit (
    input  logic a_bit,
    input  logic b_bit,
    input  logic lt_in,
    input  logic eq_in,
    output logic lt_out,
    output logic eq_out
);
    assign lt_out = lt_in | (eq_in & ~a_bit & b_bit);
    assign eq_out = eq_in & ~(a_bit ^ b_bit);
endmodule

// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: bit-serial unsigned comparator, one bit per cycle MSB first, valid/ready handshakes
// Ports: clk, rst_n (async active-low); in_valid/in_ready/a/b operand input;
//        out_valid/out_ready result handshake; lt/eq/gt result flags; bits_used = positions examined
module serial_compare_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     lt,
    output logic                     eq,
    output logic                     gt,
    output logic [$clog2(WIDTH+1)-1:0] bits_used
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t          r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b;
    logic [IW-1:0]   r_idx;
    logic [BW-1:0]   r_cnt, r_bits;
    logic            r_lt_acc, r_eq_acc, r_lt, r_eq, r_gt;
    logic            w_a_bit, w_b_bit, w_lt_next, w_eq_next, w_last;

    // mask select keeps the bit pick legal even when WIDTH=1
    assign w_a_bit = |(r_a & (WIDTH'(1) << r_idx));
    assign w_b_bit = |(r_b & (WIDTH'(1) << r_idx));

    comparator_1bit u_cell (
        .a_bit (w_a_bit),
        .b_bit (w_b_bit),
        .lt_in (r_lt_acc),
        .eq_in (r_eq_acc),
        .lt_out(w_lt_next),
        .eq_out(w_eq_next)
    );

    assign w_last    = (r_idx == '0) || (EARLY_EXIT && !w_eq_next);
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign lt        = r_lt;
    assign eq        = r_eq;
    assign gt        = r_gt;
    assign bits_used = r_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // DONE never accepts, so a release always passes through one IDLE cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid  ? COMPARE : IDLE;
            COMPARE: w_next = w_last    ? DONE    : COMPARE;
            DONE:    w_next = out_ready ? IDLE    : DONE;
            default: w_next = IDLE;
        endcase
    end

    // result registers load only on the final step so they hold through IDLE/COMPARE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_lt_acc <= 1'b0;
            r_eq_acc <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_bits   <= '0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_a      <= a;
                r_b      <= b;
                r_lt_acc <= 1'b0;
                r_eq_acc <= 1'b1;
                r_idx    <= IW'(WIDTH - 1);
                r_cnt    <= '0;
            end
            if (r_state == COMPARE) begin
                r_lt_acc <= w_lt_next;
                r_eq_acc <= w_eq_next;
                r_idx    <= r_idx - IW'(1);
                r_cnt    <= r_cnt + BW'(1);
                if (w_last) begin
                    r_lt   <= w_lt_next;
                    r_eq   <= w_eq_next;
                    r_gt   <= ~w_lt_next & ~w_eq_next;
                    r_bits <= r_cnt + BW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// tb_serial_compare_ctrl: directed checks of serial_compare_ctrl for WIDTH=8 (early exit on/off) and WIDTH=1
module tb_serial_compare_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv, ordy;
    logic [7:0] a, b;
    logic       ir1, ov1, lt1, eq1, gt1;
    logic [3:0] bu1;
    logic       ir0, ov0, lt0, eq0, gt0;
    logic [3:0] bu0;
    logic       iv2, or2, a2, b2, ir2, ov2, lt2, eq2, gt2;
    logic       bu2;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir1), .a(a), .b(b),
        .out_valid(ov1), .out_ready(ordy), .lt(lt1), .eq(eq1), .gt(gt1), .bits_used(bu1));

    serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_ee0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir0), .a(a), .b(b),
        .out_valid(ov0), .out_ready(ordy), .lt(lt0), .eq(eq0), .gt(gt0), .bits_used(bu0));

    serial_compare_ctrl #(.WIDTH(1), .EARLY_EXIT(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .out_valid(ov2), .out_ready(or2), .lt(lt2), .eq(eq2), .gt(gt2), .bits_used(bu2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // res: 0=lt 1=eq 2=gt
    task automatic check_res8(input string tag, input int res, input int bits1, input int bits0);
        check({tag, "_lt1"}, lt1, res == 0);
        check({tag, "_eq1"}, eq1, res == 1);
        check({tag, "_gt1"}, gt1, res == 2);
        check({tag, "_bu1"}, bu1, bits1);
        check({tag, "_lt0"}, lt0, res == 0);
        check({tag, "_eq0"}, eq0, res == 1);
        check({tag, "_gt0"}, gt0, res == 2);
        check({tag, "_bu0"}, bu0, bits0);
    endtask

    task automatic start8(input logic [7:0] av, input logic [7:0] bv);
        a = av;
        b = bv;
        iv = 1'b1;
        check("in_ready", ir1 & ir0, 1);
        @(posedge clk); #1;
        iv = 1'b0;
        a = ~av;
        b = ~bv;
        check("busy", ir1 | ir0, 0);
    endtask

    task automatic wait8(input int e1, input int e0);
        int cyc = 0;
        int l1 = -1;
        int l0 = -1;
        while ((l1 < 0 || l0 < 0) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (ov1 && l1 < 0) l1 = cyc;
            if (ov0 && l0 < 0) l0 = cyc;
        end
        check("lat_ee1", l1, e1);
        check("lat_ee0", l0, e0);
    endtask

    task automatic release8();
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        check("ov_clr", ov1 | ov0, 0);
        check("idle", ir1 & ir0, 1);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input int res, input int b1, input int b0);
        start8(av, bv);
        wait8(b1, b0);
        check_res8($sformatf("op_%02h_%02h", av, bv), res, b1, b0);
        release8();
    endtask

    task automatic op1(input logic av, input logic bv, input int res);
        int cyc = 0;
        a2 = av;
        b2 = bv;
        iv2 = 1'b1;
        check("w1_ready", ir2, 1);
        @(posedge clk); #1;
        iv2 = 1'b0;
        while (!ov2 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("w1_lat", cyc, 1);
        check("w1_lt", lt2, res == 0);
        check("w1_eq", eq2, res == 1);
        check("w1_gt", gt2, res == 2);
        check("w1_bu", bu2, 1);
        or2 = 1'b1;
        @(posedge clk); #1;
        or2 = 1'b0;
        check("w1_ov_clr", ov2, 0);
    endtask

    initial begin
        iv = 1'b0; ordy = 1'b0; a = '0; b = '0;
        iv2 = 1'b0; or2 = 1'b0; a2 = 1'b0; b2 = 1'b0;
        #12;
        check("rst_ir", ir1 & ir0 & ir2, 1);
        check("rst_ov", ov1 | ov0 | ov2, 0);
        check("rst_flags", {lt1, eq1, gt1, lt0, eq0, gt0, lt2, eq2, gt2}, 0);
        check("rst_bu", {bu1, bu0, bu2}, 0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        op8(8'h35, 8'h35, 1, 8, 8);
        op8(8'h12, 8'h80, 0, 1, 8);
        op8(8'h81, 8'h80, 2, 8, 8);
        op8(8'h40, 8'h60, 0, 3, 8);
        op8(8'hFF, 8'h7F, 2, 1, 8);
        op8(8'h00, 8'h00, 1, 8, 8);

        start8(8'h35, 8'h34);
        wait8(8, 8);
        check_res8("bp", 2, 8, 8);
        a = 8'h01;
        b = 8'h02;
        iv = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_ir", ir1 | ir0, 0);
            check("bp_ov", ov1 & ov0, 1);
            check_res8("bp_hold", 2, 8, 8);
        end
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        check("bp_bubble_ov", ov1 | ov0, 0);
        check("bp_bubble_ir", ir1 & ir0, 1);
        @(posedge clk); #1;
        iv = 1'b0;
        a = 8'hFE;
        b = 8'hFD;
        check("bp_accepted", ir1 | ir0, 0);
        wait8(7, 8);
        check_res8("bp_new", 0, 7, 8);
        release8();

        start8(8'h0F, 8'hF0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ov", ov1 | ov0, 0);
        check("abort_ir", ir1 & ir0, 1);
        check("abort_flags", {lt1, eq1, gt1, lt0, eq0, gt0}, 0);
        check("abort_bu", {bu1, bu0}, 0);
        #2 rst_n = 1'b1;
        op8(8'hF0, 8'h0F, 2, 1, 8);

        op1(1'b0, 1'b1, 0);
        op1(1'b1, 1'b0, 2);
        op1(1'b1, 1'b1, 1);
        op1(1'b0, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
